// File: rtl/physical_iob_word_lock.sv
// Word aligner for the LVDS receiver: steps the deserializer bitslip until a comma/SKP
// pattern is seen LOCK_CNT times in a row, then supervises lock and re-aligns on starvation.
module physical_iob_word_lock #(
   parameter int                DATA_W     = 10,
   parameter logic [DATA_W-1:0] PATTERN_N  = 10'h33c,
   parameter logic [DATA_W-1:0] PATTERN_P  = 10'h0c3,
   parameter int                SETTLE_CYC = 63,
   parameter int                HUNT_CYC   = 64,
   parameter int                LOCK_CNT   = 8,
   parameter int                LOSS_CYC   = 256,
   parameter int                SLIP_W     = 4
) (
   input  logic              i_clk,
   input  logic              local_arst_n,
   input  logic              i_start,
   input  logic              i_relock_en,
   input  logic [DATA_W-1:0] i_data,
   output logic [SLIP_W-1:0] o_slipbits,
   output logic              o_bitslip,
   output logic              o_run,
   output logic              o_done,
   output logic              o_fail,
   output logic              o_lost,
   output logic [7:0]        o_relock_cnt
);

   localparam int CNT_MAX_A = (SETTLE_CYC > HUNT_CYC) ? SETTLE_CYC : HUNT_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > LOSS_CYC) ? CNT_MAX_A : LOSS_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [SLIP_W-1:0] MAX_SLIP = SLIP_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_HUNT,
      S_LOCKED,
      S_FAIL
   } state_t;

   state_t            state, state_nx;
   logic              r_start;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [7:0]        cons, cons_nx;
   logic [SLIP_W-1:0] slips, slip_nx;
   logic [7:0]        relock, relock_nx;
   logic              bitslip_nx, lost_nx;
   logic              start_flag, match;

   assign start_flag = i_start & ~r_start;
   assign match      = (r_data == PATTERN_N) || (r_data == PATTERN_P);

   // cnt is shared: settle wait, hunt timer and starvation counter, each cleared on state entry.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_nx   = state;
      cnt_nx     = cnt;
      cons_nx    = cons;
      slip_nx    = slips;
      relock_nx  = relock;
      bitslip_nx = 1'b0;
      lost_nx    = 1'b0;
      if (start_flag) begin
         state_nx  = S_SETTLE;
         cnt_nx    = '0;
         cons_nx   = '0;
         slip_nx   = '0;
         relock_nx = '0;
      end else begin
         unique case (state)
            S_SETTLE: begin
               if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                  state_nx = S_HUNT;
                  cnt_nx   = '0;
                  cons_nx  = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            S_HUNT: begin
               if (match && (cons == 8'(LOCK_CNT - 1))) begin
                  state_nx = S_LOCKED;
                  cnt_nx   = '0;
                  cons_nx  = '0;
               end else if (cnt == CNT_W'(HUNT_CYC - 1)) begin
                  cnt_nx  = '0;
                  cons_nx = '0;
                  if (slips == MAX_SLIP) begin
                     state_nx = S_FAIL;
                  end else begin
                     state_nx   = S_SETTLE;
                     slip_nx    = slips + 1'b1;
                     bitslip_nx = 1'b1;
                  end
               end else begin
                  cnt_nx  = cnt + 1'b1;
                  cons_nx = match ? cons + 8'd1 : 8'd0;
               end
            end
            S_LOCKED: begin
               if (match) begin
                  cnt_nx = '0;
               end else if (cnt == CNT_W'(LOSS_CYC - 1)) begin
                  lost_nx = 1'b1;
                  cnt_nx  = '0;
                  if (i_relock_en) begin
                     state_nx  = S_SETTLE;
                     slip_nx   = '0;
                     relock_nx = (relock == 8'hff) ? relock : relock + 8'd1;
                  end else begin
                     state_nx = S_FAIL;
                  end
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs are registered from the next-state decision.
   always_ff @(posedge i_clk or negedge local_arst_n) begin
      if (!local_arst_n) begin
         state     <= S_IDLE;
         r_start   <= 1'b0;
         r_data    <= '0;
         cnt       <= '0;
         cons      <= '0;
         slips     <= '0;
         relock    <= '0;
         o_bitslip <= 1'b0;
         o_lost    <= 1'b0;
         o_run     <= 1'b0;
         o_done    <= 1'b0;
         o_fail    <= 1'b0;
      end else begin
         state     <= state_nx;
         r_start   <= i_start;
         r_data    <= i_data;
         cnt       <= cnt_nx;
         cons      <= cons_nx;
         slips     <= slip_nx;
         relock    <= relock_nx;
         o_bitslip <= bitslip_nx;
         o_lost    <= lost_nx;
         o_run     <= (state_nx == S_SETTLE) || (state_nx == S_HUNT);
         o_done    <= (state_nx == S_LOCKED);
         o_fail    <= (state_nx == S_FAIL);
      end
   end

   assign o_slipbits   = slips;
   assign o_relock_cnt = relock;

endmodule
